// File: rtl/alu_sequencer_if.sv
// Handshake and datapath-side bundle between fetch/decode, the ALU and the sequencer.
// Master drives instructions and ALU flags; slave (sequencer) drives control and status.
// No storage here; all timing lives in the sequencer.
interface alu_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] op;
  logic [3:0] cond;
  logic       alu_c;
  logic       alu_l;
  logic       alu_f;
  logic       alu_z;
  logic       alu_n;
  logic [3:0] aluControl;
  logic       reg_we;
  logic [4:0] psr;
  logic       branch_taken;
  logic       done;
  logic       illegal;

  modport master (
    output instr_valid, op, cond, alu_c, alu_l, alu_f, alu_z, alu_n,
    input  instr_ready, aluControl, reg_we, psr, branch_taken, done, illegal
  );

  modport slave (
    input  instr_valid, op, cond, alu_c, alu_l, alu_f, alu_z, alu_n,
    output instr_ready, aluControl, reg_we, psr, branch_taken, done, illegal
  );
endinterface

// File: rtl/alu_sequencer.sv
// ALU control sequencer: decodes one op per handshake, drives aluControl, keeps PSR {C,L,F,Z,N}.
// Latency: accept at edge 0, EXEC in cycle 1, done pulse in cycle 2; one instruction per 3 cycles.
// Backpressure: instr_ready is high only in IDLE; instr_valid is ignored elsewhere.
module alu_sequencer #(
  parameter logic [4:0] PSR_RESET = 5'b00000
) (
  input  logic            clk,
  input  logic            reset,
  alu_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_CMP   = 4'h3;
  localparam logic [3:0] OP_BCOND = 4'h9;
  localparam logic [3:0] OP_CLRF  = 4'hA;

  // PSR bit positions within {C,L,F,Z,N}
  localparam int PC = 4;
  localparam int PL = 3;
  localparam int PF = 2;
  localparam int PZ = 1;
  localparam int PN = 0;

  state_t     state_q;
  logic [3:0] op_q;
  logic [3:0] cond_q;
  logic [4:0] psr_q;
  logic [3:0] alu_ctrl_q;
  logic       reg_we_q;
  logic       ready_q;
  logic       done_q;
  logic       illegal_q;
  logic       taken_q;

  logic [3:0] alu_ctrl_d;
  logic       reg_we_d;
  logic [4:0] psr_d;
  logic       taken_d;
  logic       illegal_d;

  // Decode the incoming op into the control word that will be registered for EXEC
  always_comb begin
    alu_ctrl_d = 4'b0000;
    reg_we_d   = 1'b0;
    unique case (bus.op)
      4'h1:    begin alu_ctrl_d = 4'b1000; reg_we_d = 1'b1; end
      4'h2:    begin alu_ctrl_d = 4'b0001; reg_we_d = 1'b1; end
      4'h3:    begin alu_ctrl_d = 4'b0010; reg_we_d = 1'b0; end
      4'h4:    begin alu_ctrl_d = 4'b0011; reg_we_d = 1'b1; end
      4'h5:    begin alu_ctrl_d = 4'b0100; reg_we_d = 1'b1; end
      4'h6:    begin alu_ctrl_d = 4'b0101; reg_we_d = 1'b1; end
      4'h7:    begin alu_ctrl_d = 4'b0110; reg_we_d = 1'b1; end
      4'h8:    begin alu_ctrl_d = 4'b0111; reg_we_d = 1'b1; end
      default: begin alu_ctrl_d = 4'b0000; reg_we_d = 1'b0; end
    endcase
  end

  // PSR commit value, branch resolution and illegal detection for the op currently in EXEC
  always_comb begin
    psr_d = psr_q;
    unique case (op_q)
      OP_ADD, OP_SUB: begin
        psr_d[PC] = bus.alu_c;
        psr_d[PF] = bus.alu_f;
      end
      OP_CMP: begin
        psr_d[PL] = bus.alu_l;
        psr_d[PZ] = bus.alu_z;
        psr_d[PN] = bus.alu_n;
      end
      OP_CLRF: psr_d = 5'b00000;
      default: psr_d = psr_q;
    endcase

    // Branches always see the committed PSR, never this cycle's ALU flags
    taken_d = 1'b0;
    unique case (cond_q)
      4'h0: taken_d =  psr_q[PZ];
      4'h1: taken_d = !psr_q[PZ];
      4'h2: taken_d =  psr_q[PC];
      4'h3: taken_d = !psr_q[PC];
      4'h4: taken_d = !psr_q[PL] && !psr_q[PZ];
      4'h5: taken_d =  psr_q[PL] ||  psr_q[PZ];
      4'h6: taken_d = !psr_q[PN] && !psr_q[PZ];
      4'h7: taken_d =  psr_q[PN] ||  psr_q[PZ];
      4'h8: taken_d =  psr_q[PF];
      4'h9: taken_d = !psr_q[PF];
      4'hA: taken_d =  psr_q[PL];
      4'hB: taken_d = !psr_q[PL];
      4'hC: taken_d =  psr_q[PN];
      4'hD: taken_d = !psr_q[PN];
      4'hE: taken_d = 1'b1;
      default: taken_d = 1'b0;
    endcase
    if (op_q != OP_BCOND) taken_d = 1'b0;

    illegal_d = (op_q >= 4'hB);
  end

  // Sequencer FSM with all outputs registered; reset discards any in-flight op
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= 4'h0;
      cond_q     <= 4'h0;
      psr_q      <= PSR_RESET;
      alu_ctrl_q <= 4'b0000;
      reg_we_q   <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          taken_q   <= 1'b0;
          if (bus.instr_valid) begin
            op_q       <= bus.op;
            cond_q     <= bus.cond;
            alu_ctrl_q <= alu_ctrl_d;
            reg_we_q   <= reg_we_d;
            ready_q    <= 1'b0;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          psr_q      <= psr_d;
          taken_q    <= taken_d;
          illegal_q  <= illegal_d;
          done_q     <= 1'b1;
          alu_ctrl_q <= 4'b0000;
          reg_we_q   <= 1'b0;
          state_q    <= DONE;
        end
        DONE: begin
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          taken_q   <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready  = ready_q;
  assign bus.aluControl   = alu_ctrl_q;
  assign bus.reg_we       = reg_we_q;
  assign bus.psr          = psr_q;
  assign bus.branch_taken = taken_q;
  assign bus.done         = done_q;
  assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed steps from the test plan followed by random instructions.
// Expected values come from a flag-level reference model of the PSR and the op/condition tables.
module tb_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  alu_sequencer_if bus();

  alu_sequencer #(.PSR_RESET(5'b00000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: individual status flags
  logic m_c, m_l, m_f, m_z, m_n;

  // op -> aluControl and register write enable, straight from the op table
  logic [3:0] ctrl_tbl [16];
  logic       we_tbl   [16];

  function automatic logic [4:0] model_psr();
    return {m_c, m_l, m_f, m_z, m_n};
  endfunction

  function automatic logic cond_holds(input logic [3:0] c);
    case (c)
      4'h0: return m_z;
      4'h1: return !m_z;
      4'h2: return m_c;
      4'h3: return !m_c;
      4'h4: return !m_l && !m_z;
      4'h5: return m_l || m_z;
      4'h6: return !m_n && !m_z;
      4'h7: return m_n || m_z;
      4'h8: return m_f;
      4'h9: return !m_f;
      4'hA: return m_l;
      4'hB: return !m_l;
      4'hC: return m_n;
      4'hD: return !m_n;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_apply(input logic [3:0] op, input logic c, l, f, z, n);
    if (op == 4'h1 || op == 4'h2) begin
      m_c = c; m_f = f;
    end else if (op == 4'h3) begin
      m_l = l; m_z = z; m_n = n;
    end else if (op == 4'hA) begin
      {m_c, m_l, m_f, m_z, m_n} = 5'b00000;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction and check EXEC, DONE and the following IDLE cycle
  task automatic run_instr(input logic [3:0] op, input logic [3:0] cond,
                           input logic c, l, f, z, n);
    int budget;
    logic exp_taken;
    logic exp_illegal;
    budget = 20;
    while (bus.instr_ready !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    check("ready_before_issue", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.op          = op;
    bus.cond        = cond;
    tick();
    // EXEC: op/cond no longer matter, ALU flags are presented now
    bus.instr_valid = 1'b0;
    bus.op          = 4'($urandom);
    bus.cond        = 4'($urandom);
    {bus.alu_c, bus.alu_l, bus.alu_f, bus.alu_z, bus.alu_n} = {c, l, f, z, n};
    check("exec_aluControl", bus.aluControl, ctrl_tbl[op]);
    check("exec_reg_we", bus.reg_we, we_tbl[op]);
    check("exec_ready", bus.instr_ready, 0);
    check("exec_done", bus.done, 0);
    exp_taken   = (op == 4'h9) && cond_holds(cond);
    exp_illegal = (op >= 4'hB);
    model_apply(op, c, l, f, z, n);
    tick();
    // DONE
    {bus.alu_c, bus.alu_l, bus.alu_f, bus.alu_z, bus.alu_n} = 5'($urandom);
    check("done_pulse", bus.done, 1);
    check("done_illegal", bus.illegal, exp_illegal);
    check("done_branch", bus.branch_taken, exp_taken);
    check("done_aluControl", bus.aluControl, 0);
    check("done_reg_we", bus.reg_we, 0);
    check("done_ready", bus.instr_ready, 0);
    check("done_psr", bus.psr, model_psr());
    tick();
    // back in IDLE
    check("idle_done", bus.done, 0);
    check("idle_illegal", bus.illegal, 0);
    check("idle_branch", bus.branch_taken, 0);
    check("idle_ready", bus.instr_ready, 1);
    check("idle_psr", bus.psr, model_psr());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] stream_ops [3];
    int hs;

    ctrl_tbl = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    we_tbl   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    {m_c, m_l, m_f, m_z, m_n} = 5'b00000;

    // Reset
    reset = 1'b0;
    bus.instr_valid = 1'b0;
    bus.op = 4'h0;
    bus.cond = 4'h0;
    {bus.alu_c, bus.alu_l, bus.alu_f, bus.alu_z, bus.alu_n} = 5'b00000;
    tick();
    tick();
    check("rst_psr", bus.psr, 5'b00000);
    check("rst_aluControl", bus.aluControl, 0);
    check("rst_reg_we", bus.reg_we, 0);
    check("rst_done", bus.done, 0);
    check("rst_illegal", bus.illegal, 0);
    check("rst_branch", bus.branch_taken, 0);
    reset = 1'b1;
    tick();
    check("post_rst_ready", bus.instr_ready, 1);

    // CMP with L=1,N=1,Z=0
    run_instr(4'h3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("cmp_psr_literal", bus.psr, 5'b01001);
    // ADD with C=1,F=1 keeps L and N
    run_instr(4'h1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("add_psr_literal", bus.psr, 5'b11101);

    // CMP setting Z, then branches
    run_instr(4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr(4'h9, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // EQ -> taken
    run_instr(4'h9, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // NE -> not taken
    run_instr(4'h9, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // UC
    run_instr(4'h9, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);  // NV

    // Undefined op
    run_instr(4'hC, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // Back-to-back stream with instr_valid held high for 9 cycles
    stream_ops = '{4'h7, 4'h6, 4'h2};
    hs = 0;
    {bus.alu_c, bus.alu_l, bus.alu_f, bus.alu_z, bus.alu_n} = 5'b10111;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 0) bus.op = stream_ops[i / 3];
      check("stream_ready", bus.instr_ready, (i % 3 == 0) ? 8'd1 : 8'd0);
      if (i % 3 == 1) begin
        check("stream_aluControl", bus.aluControl, ctrl_tbl[stream_ops[i / 3]]);
        check("stream_reg_we", bus.reg_we, we_tbl[stream_ops[i / 3]]);
      end
      if (i % 3 == 2) check("stream_done", bus.done, 1);
      if (bus.instr_ready === 1'b1) hs++;
      tick();
    end
    bus.instr_valid = 1'b0;
    model_apply(4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("stream_handshakes", 8'(hs), 3);
    check("stream_psr", bus.psr, model_psr());

    // Reset during EXEC of SUB discards it
    run_instr(4'h1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.instr_valid = 1'b1;
    bus.op = 4'h2;
    tick();
    bus.instr_valid = 1'b0;
    bus.alu_c = 1'b1;
    check("rst_exec_aluControl", bus.aluControl, 4'b0001);
    reset = 1'b0;
    tick();
    {m_c, m_l, m_f, m_z, m_n} = 5'b00000;
    check("rst_exec_psr", bus.psr, 5'b00000);
    check("rst_exec_done", bus.done, 0);
    check("rst_exec_aluControl0", bus.aluControl, 0);
    reset = 1'b1;
    tick();
    check("rst_exec_ready", bus.instr_ready, 1);
    check("rst_exec_no_done", bus.done, 0);
    check("rst_exec_psr_hold", bus.psr, 5'b00000);
    run_instr(4'h1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr(4'hA, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("clrf_psr_literal", bus.psr, 5'b00000);

    // Random instructions against the model
    for (int k = 0; k < 60; k++) begin
      logic [4:0] fl;
      fl = 5'($urandom);
      run_instr(4'($urandom), 4'($urandom_range(15, 0)), fl[4], fl[3], fl[2], fl[1], fl[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
